anim_scheduler: RTL and testbench
=================================

Name: anim_scheduler

Overview:
- Frame-level controller for the animated-object datapath.
- Takes the end-of-frame animate pulse from the VGA timing generator and turns it into per-object update strobes, one object per clock, in fixed index order.
- Adds a per-object frame divider, a run/pause/single-step control, a serviced-frame counter and an overrun flag.
- Sits between vga640x480 (o_animate) and the square instances (i_animate); one scheduler drives all objects.

Parameters:
N_OBJ, 3, number of scheduled objects (1..16)
DIV_W, 4, width of each per-object divider field
FRAME_W, 16, width of the serviced-frame counter

Ports:
i_clk  input  1  system clock (100 MHz)
i_rst  input  1  reset, asynchronous, active-high
i_animate  input  1  one-cycle end-of-frame pulse from timing generator
i_run  input  1  1 = free-run every frame; 0 = paused
i_step  input  1  one-cycle pulse: while paused, service exactly one upcoming frame
i_en  input  N_OBJ  per-object enable
i_div  input  N_OBJ*DIV_W  per-object divider; object k field is [k*DIV_W +: DIV_W]; object k updates every (div+1)-th serviced frame
i_clr_ovr  input  1  clears o_overrun
o_obj_stb  output  N_OBJ  registered one-hot update strobes, one cycle each
o_busy  output  1  high while dispatching
o_frame  output  FRAME_W  count of serviced frames
o_overrun  output  1  sticky: i_animate arrived while busy

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state IDLE; idx 0; step_pending 0; all divider counters 0. Takes effect immediately, including mid-dispatch. No strobe is issued after reset until a new accepted i_animate.
- State IDLE:
  - i_animate accepted when i_run=1, or step_pending=1, or i_step=1 in the same cycle.
  - On acceptance: go to DISPATCH, idx<=0, o_busy<=1, step_pending<=0.
  - If paused with no step: i_animate is ignored. No overrun, no count.
- step_pending:
  - Set by i_step while i_run=0 and not consumed that cycle.
  - Ignored while i_run=1.
  - Cleared when a frame is accepted.
  - Multiple steps before a frame collapse into one.
- State DISPATCH, one object per clock for idx = 0..N_OBJ-1. Let cnt[idx] be that object's divider counter.
  - If i_en[idx]=0: cnt[idx]<=0 and no strobe.
  - Else if cnt[idx] >= div[idx]: o_obj_stb[idx]<=1 for one cycle and cnt[idx]<=0. Using >= makes a divider lowered mid-count fire at once.
  - Else: cnt[idx]<=cnt[idx]+1.
  - i_div and i_en are sampled in the cycle their object is evaluated.
  - After idx=N_OBJ-1: go to IDLE, o_busy<=0, o_frame<=o_frame+1. o_frame wraps modulo 2^FRAME_W.
- Timing: if i_animate is accepted at edge E0:
  - Object k's strobe is high from edge E(1+k) to E(2+k).
  - o_busy is high from E0 to E(N_OBJ).
  - o_frame updates at E(N_OBJ).
  - Dispatch latency is N_OBJ cycles. The next frame can be accepted at the first IDLE cycle.
- Overrun: i_animate while in DISPATCH sets o_overrun and is otherwise dropped (no queueing).
  - i_clr_ovr clears it.
  - If i_clr_ovr and a new overrun occur in the same cycle, set wins.
- o_obj_stb is never multi-hot. It is all-zero in IDLE.
- Changing i_run mid-dispatch does not abort the frame in progress.

Test Plan:
1. Reset, i_run=1, i_en=3'b111, all div=0, one i_animate pulse -> o_obj_stb = 001, 010, 100 on the three cycles after acceptance; o_busy high 3 cycles; o_frame=1.
2. div={obj0:0, obj1:1, obj2:3}, i_run=1, 8 frames -> obj0 strobes 8 times, obj1 4 times (frames 2,4,6,8), obj2 2 times (frames 4,8); o_frame=8.
3. i_run=0, three i_animate pulses -> no strobes, o_frame unchanged; then i_step, then two i_animate -> exactly one frame serviced (o_frame +1).
4. i_animate pulsed again 1 cycle after acceptance -> o_overrun=1, only one frame's strobes, o_frame +1; i_clr_ovr -> o_overrun=0.
5. i_en[1]=0 with div1=1 over 4 frames, then re-enabled -> no obj1 strobes while disabled; first strobe on the 2nd frame after re-enable.
6. Assert i_rst during the cycle obj1 strobes -> all outputs 0 immediately; obj2 not strobed; next accepted frame restarts at obj0 with o_frame=1.

Source files
------------

// File: rtl/anim_scheduler.sv
// Frame-level animation scheduler: turns each accepted end-of-frame pulse into
// per-object update strobes, one object per clock, with per-object frame dividers.
module anim_scheduler #(
    parameter int N_OBJ   = 3,
    parameter int DIV_W   = 4,
    parameter int FRAME_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_animate,
    input  logic                     i_run,
    input  logic                     i_step,
    input  logic [N_OBJ-1:0]         i_en,
    input  logic [N_OBJ*DIV_W-1:0]   i_div,
    input  logic                     i_clr_ovr,
    output logic [N_OBJ-1:0]         o_obj_stb,
    output logic                     o_busy,
    output logic [FRAME_W-1:0]       o_frame,
    output logic                     o_overrun
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 step_pending_reg, step_pending_next;
    logic [N_OBJ-1:0]     stb_reg, stb_next;
    logic                 busy_reg, busy_next;
    logic [FRAME_W-1:0]   frame_reg, frame_next;
    logic                 overrun_reg, overrun_next;

    logic                 accept;
    logic                 last_obj;
    logic                 dispatching;

    assign dispatching = (state_reg == DISPATCH);
    assign last_obj    = (idx_reg == IDX_W'(N_OBJ - 1));
    // A step arriving together with the animate pulse is enough to accept it.
    assign accept      = i_animate && (i_run || step_pending_reg || i_step);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            step_pending_reg <= 1'b0;
            stb_reg          <= '0;
            busy_reg         <= 1'b0;
            frame_reg        <= '0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            step_pending_reg <= step_pending_next;
            stb_reg          <= stb_next;
            busy_reg         <= busy_next;
            frame_reg        <= frame_next;
            overrun_reg      <= overrun_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        step_pending_next = step_pending_reg;
        busy_next         = busy_reg;
        frame_next        = frame_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next        = DISPATCH;
                    idx_next          = '0;
                    busy_next         = 1'b1;
                    step_pending_next = 1'b0;
                end else if (i_step && !i_run) begin
                    step_pending_next = 1'b1;
                end
            end
            DISPATCH: begin
                if (i_step && !i_run) begin
                    step_pending_next = 1'b1;
                end
                if (last_obj) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    busy_next  = 1'b0;
                    frame_next = frame_reg + 1'b1;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Set wins over clear when a dropped pulse and a clear coincide.
    assign overrun_next = (overrun_reg && !i_clr_ovr) || (i_animate && dispatching);

    generate
        for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
            logic [DIV_W-1:0] cnt_reg, cnt_next;
            logic [DIV_W-1:0] div_val;
            logic             selected;
            logic             fire;

            assign div_val  = i_div[gi*DIV_W +: DIV_W];
            assign selected = dispatching && (idx_reg == IDX_W'(gi));

            // >= lets a divider lowered below the running count fire immediately.
            always_comb begin
                cnt_next = cnt_reg;
                fire     = 1'b0;
                if (selected) begin
                    if (!i_en[gi]) begin
                        cnt_next = '0;
                    end else if (cnt_reg >= div_val) begin
                        cnt_next = '0;
                        fire     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign stb_next[gi] = fire;
        end
    endgenerate

    assign o_obj_stb = stb_reg;
    assign o_busy    = busy_reg;
    assign o_frame   = frame_reg;
    assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_anim_scheduler.sv
// Self-checking bench for anim_scheduler: directed scenarios plus randomized
// traffic compared cycle by cycle against a frame-level reference model.
module tb_anim_scheduler;

    localparam int N_OBJ   = 3;
    localparam int DIV_W   = 4;
    localparam int FRAME_W = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   animate = 1'b0;
    logic                   run = 1'b0;
    logic                   step = 1'b0;
    logic [N_OBJ-1:0]       en = '0;
    logic [N_OBJ*DIV_W-1:0] div = '0;
    logic                   clr_ovr = 1'b0;
    logic [N_OBJ-1:0]       obj_stb;
    logic                   busy;
    logic [FRAME_W-1:0]     frame;
    logic                   overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state (frame-level view)
    int  e        = 0;
    int  e0       = -100;
    int  busy_end = -100;
    bit  fire_m [N_OBJ];
    int  cnt_m  [N_OBJ];
    bit  pend_m   = 0;
    bit  ovr_m    = 0;
    int  frame_m  = 0;
    int  stb_count [N_OBJ];

    anim_scheduler #(.N_OBJ(N_OBJ), .DIV_W(DIV_W), .FRAME_W(FRAME_W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_animate (animate),
        .i_run     (run),
        .i_step    (step),
        .i_en      (en),
        .i_div     (div),
        .i_clr_ovr (clr_ovr),
        .o_obj_stb (obj_stb),
        .o_busy    (busy),
        .o_frame   (frame),
        .o_overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic int div_of(input int k);
        logic [N_OBJ*DIV_W-1:0] d;
        d = div;
        return int'(d[k*DIV_W +: DIV_W]);
    endfunction

    task automatic model_reset();
        e0 = -100;
        busy_end = -100;
        pend_m = 0;
        ovr_m = 0;
        frame_m = 0;
        for (int k = 0; k < N_OBJ; k++) begin
            cnt_m[k] = 0;
            fire_m[k] = 0;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < N_OBJ; k++) stb_count[k] = 0;
    endtask

    // One clock: drive inputs at negedge, advance the model at posedge, compare 1 ns later.
    task automatic cycle(input bit an, input bit rn, input bit st, input bit clr);
        bit idle;
        int exp_stb;
        int exp_busy;
        @(negedge clk);
        animate = an;
        run     = rn;
        step    = st;
        clr_ovr = clr;
        @(posedge clk);
        e++;
        idle = (e > busy_end);
        if (e == busy_end) frame_m = (frame_m + 1) % (1 << FRAME_W);
        if (idle && an && (rn || pend_m || st)) begin
            e0 = e;
            busy_end = e + N_OBJ;
            pend_m = 0;
            for (int k = 0; k < N_OBJ; k++) begin
                if (!en[k]) begin
                    cnt_m[k] = 0;
                    fire_m[k] = 0;
                end else if (cnt_m[k] >= div_of(k)) begin
                    cnt_m[k] = 0;
                    fire_m[k] = 1;
                end else begin
                    cnt_m[k]++;
                    fire_m[k] = 0;
                end
            end
        end else if (st && !rn) begin
            pend_m = 1;
        end
        ovr_m = (ovr_m && !clr) || (an && !idle);
        exp_busy = (e >= e0 && e < busy_end) ? 1 : 0;
        exp_stb = 0;
        if (e > e0 && e <= busy_end && fire_m[e - e0 - 1]) exp_stb = 1 << (e - e0 - 1);
        #1;
        for (int k = 0; k < N_OBJ; k++) if (obj_stb[k]) stb_count[k]++;
        check("obj_stb", 32'(obj_stb), 32'(exp_stb));
        check("busy", 32'(busy), 32'(exp_busy));
        check("frame", 32'(frame), 32'(frame_m));
        check("overrun", 32'(overrun), 32'(ovr_m));
        $display("edge %0d an=%0b run=%0b step=%0b clr=%0b -> stb=%b busy=%0b frame=%0d ovr=%0b",
                 e, an, rn, st, clr, obj_stb, busy, frame, overrun);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        animate = 1'b0;
        step = 1'b0;
        clr_ovr = 1'b0;
        #1;
        check("rst_stb", 32'(obj_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input bit rn);
        cycle(1, rn, 0, 0);
        for (int i = 0; i < N_OBJ + 1; i++) cycle(0, rn, 0, 0);
    endtask

    initial begin
        int start_frame;
        model_reset();
        clear_counts();
        #2;
        check("init_stb", 32'(obj_stb), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: all divs 0, all enabled, one frame
        en = 3'b111;
        div = '0;
        run_frame(1);
        check("t1_frame", 32'(frame), 32'd1);
        for (int k = 0; k < N_OBJ; k++) check("t1_count", 32'(stb_count[k]), 32'd1);

        // 2: dividers 0,1,3 over 8 frames
        do_reset();
        clear_counts();
        div = {4'd3, 4'd1, 4'd0};
        for (int f = 0; f < 8; f++) run_frame(1);
        check("t2_cnt0", 32'(stb_count[0]), 32'd8);
        check("t2_cnt1", 32'(stb_count[1]), 32'd4);
        check("t2_cnt2", 32'(stb_count[2]), 32'd2);
        check("t2_frame", 32'(frame), 32'd8);

        // 3: paused, then a single step
        div = '0;
        start_frame = int'(frame);
        for (int i = 0; i < 3; i++) run_frame(0);
        check("t3_paused", 32'(frame), 32'(start_frame));
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        run_frame(0);
        run_frame(0);
        check("t3_step", 32'(frame), 32'(start_frame + 1));

        // 4: overrun one cycle after acceptance, then clear
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < N_OBJ; i++) cycle(0, 1, 0, 0);
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_frame", 32'(frame), 32'(start_frame + 2));
        cycle(0, 1, 0, 1);
        check("t4_clear", 32'(overrun), 32'd0);

        // 5: obj1 disabled for 4 frames, then re-enabled
        clear_counts();
        div = {4'd0, 4'd1, 4'd0};
        en = 3'b101;
        for (int f = 0; f < 4; f++) run_frame(1);
        check("t5_off", 32'(stb_count[1]), 32'd0);
        en = 3'b111;
        run_frame(1);
        check("t5_first", 32'(stb_count[1]), 32'd0);
        run_frame(1);
        check("t5_second", 32'(stb_count[1]), 32'd1);

        // 6: reset during the obj1 strobe cycle
        do_reset();
        div = '0;
        clear_counts();
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("t6_obj1", 32'(obj_stb), 32'b010);
        do_reset();
        for (int i = 0; i < N_OBJ + 1; i++) cycle(0, 1, 0, 0);
        check("t6_no_obj2", 32'(stb_count[2]), 32'd0);
        run_frame(1);
        check("t6_frame", 32'(frame), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit an, rn, st, clr;
            if (e + 1 > busy_end && $urandom_range(0, 3) == 0) begin
                en  = N_OBJ'($urandom);
                div = (N_OBJ*DIV_W)'($urandom);
            end
            an  = ($urandom_range(0, 3) == 0);
            rn  = ($urandom_range(0, 4) != 0);
            st  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 7) == 0);
            cycle(an, rn, st, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
